transconv_pe_sequencer: RTL and testbench

Parametrised multi-pass sequencer for the transposed-convolution PE array. It drives the skewed (diagonal wavefront) load/accumulate/output enables for `NUM_PE` processing elements over `num_iterations` MAC steps, and repeats the whole wavefront for `num_passes` output tiles without returning to the scheduler. It also freezes cleanly when the BRAM feed is not valid. It sits between the instruction scheduler (opcode `8'h03`) and the PE array in `TransConv_Control`.

---
 rtl/transconv_pe_sequencer_if.sv | 41 ++++
 rtl/transconv_pe_sequencer.sv | 130 +++++++++++++
 tb/tb_transconv_pe_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/transconv_pe_sequencer_if.sv
// Scheduler <-> sequencer bundle for the transposed-convolution PE array.
// Master is the scheduler side, slave is transconv_pe_sequencer.
interface transconv_pe_sequencer_if #(
  parameter int NUM_PE = 16,
  parameter int ITER_W = 9,
  parameter int PASS_W = 6
);
  // Handshake: start is a level request that counts only while the sequencer
  // is idle and only with opcode 8'h03. No ready is returned. An accepted job
  // raises busy from the next cycle until done pulses for one cycle with busy
  // low. A rejected job pulses cfg_err instead. data_valid gates RUN progress.
  logic                start;
  logic [7:0]          instr_code;
  logic [ITER_W-1:0]   num_iterations;
  logic [PASS_W-1:0]   num_passes;
  logic                data_valid;
  logic [NUM_PE-1:0]   en_weight_load;
  logic [NUM_PE-1:0]   en_ifmap_load;
  logic [NUM_PE-1:0]   en_psum;
  logic [NUM_PE-1:0]   clear_psum;
  logic [NUM_PE-1:0]   en_output;
  logic [NUM_PE-1:0]   ifmap_sel_ctrl;
  logic                busy;
  logic                done;
  logic                cfg_err;
  logic [PASS_W-1:0]   pass_count;
  logic [ITER_W:0]     phase_count;
  logic [1:0]          state_dbg;

  modport master (
    output start, instr_code, num_iterations, num_passes, data_valid,
    input  en_weight_load, en_ifmap_load, en_psum, clear_psum, en_output,
           ifmap_sel_ctrl, busy, done, cfg_err, pass_count, phase_count, state_dbg
  );

  modport slave (
    input  start, instr_code, num_iterations, num_passes, data_valid,
    output en_weight_load, en_ifmap_load, en_psum, clear_psum, en_output,
           ifmap_sel_ctrl, busy, done, cfg_err, pass_count, phase_count, state_dbg
  );
endinterface

// File: rtl/transconv_pe_sequencer.sv
// Multi-pass diagonal-wavefront enable sequencer for the transposed-conv PE array.
// Define TCONV_SEQ_STALL_EN to let data_valid freeze RUN; otherwise it is ignored.
module transconv_pe_sequencer #(
  parameter int NUM_PE = 16,
  parameter int ITER_W = 9,
  parameter int PASS_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  transconv_pe_sequencer_if.slave bus
);
  localparam int PH_W = ITER_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ITER_W-1:0] n_q, n_d;
  logic [PASS_W-1:0] p_q, p_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              cfg_err_q, cfg_err_d;

  logic              qual;
  logic              in_run;
  logic              pass_end;
  logic              last_pass;
  logic [PH_W-1:0]   n_ext;
  logic [PH_W-1:0]   last_phase;
  logic [NUM_PE-1:0] win;
  logic [NUM_PE-1:0] out_hit;

`ifdef TCONV_SEQ_STALL_EN
  assign qual = bus.data_valid;
`else
  logic unused_data_valid;
  assign unused_data_valid = bus.data_valid;
  assign qual = 1'b1;
`endif

  // Compare in ITER_W+1 bits so i+N never wraps.
  assign n_ext      = {1'b0, n_q};
  assign last_phase = n_ext + PH_W'(NUM_PE - 1);
  assign in_run     = (state_q == S_RUN);
  assign pass_end   = in_run && qual && (phase_q == last_phase);
  assign last_pass  = (pass_q == p_q - PASS_W'(1));

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    p_d       = p_q;
    pass_d    = pass_q;
    phase_d   = phase_q;
    cfg_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && bus.instr_code == 8'h03) begin
          if (bus.num_iterations != '0 && bus.num_passes != '0) begin
            n_d     = bus.num_iterations;
            p_d     = bus.num_passes;
            pass_d  = '0;
            phase_d = '0;
            state_d = S_CLEAR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        phase_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (pass_end) begin
          if (last_pass) begin
            state_d = S_DONE;
          end else begin
            pass_d  = pass_q + PASS_W'(1);
            phase_d = '0;
            state_d = S_CLEAR;
          end
        end else if (qual) begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      p_q       <= '0;
      pass_q    <= '0;
      phase_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      p_q       <= p_d;
      pass_q    <= pass_d;
      phase_q   <= phase_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // PE i is active on phases [i, i+N) and emits its result at phase i+N.
  for (genvar g = 0; g < NUM_PE; g++) begin : g_pe
    localparam logic [PH_W-1:0] IDX = PH_W'(g);
    assign win[g]     = (phase_q >= IDX) && (phase_q < IDX + n_ext);
    assign out_hit[g] = (phase_q == IDX + n_ext);
  end

  assign bus.en_weight_load = (in_run && qual) ? win : '0;
  assign bus.en_ifmap_load  = (in_run && qual) ? win : '0;
  assign bus.en_psum        = (in_run && qual) ? win : '0;
  assign bus.en_output      = (in_run && qual) ? out_hit : '0;
  assign bus.clear_psum     = (state_q == S_CLEAR) ? '1 : '0;
  assign bus.ifmap_sel_ctrl = in_run ? NUM_PE'(1) : '0;
  assign bus.busy           = (state_q == S_CLEAR) || in_run;
  assign bus.done           = (state_q == S_DONE);
  assign bus.cfg_err        = cfg_err_q;
  assign bus.pass_count     = pass_q;
  assign bus.phase_count    = phase_q;
  assign bus.state_dbg      = state_q;
endmodule

// File: tb/tb_transconv_pe_sequencer.sv
// Randomized self-checking bench for transconv_pe_sequencer against a cycle trace model.
module tb_transconv_pe_sequencer;
  localparam int NUM_PE = 16;
  localparam int ITER_W = 9;
  localparam int PASS_W = 6;
  localparam int PH_W   = ITER_W + 1;
  localparam int W      = 6 * NUM_PE + 3 + PASS_W + PH_W;
  localparam int EW     = W + 1;
  localparam int DV_N   = 1024;
`ifdef TCONV_SEQ_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  transconv_pe_sequencer_if #(.NUM_PE(NUM_PE), .ITER_W(ITER_W), .PASS_W(PASS_W)) bus ();

  transconv_pe_sequencer #(.NUM_PE(NUM_PE), .ITER_W(ITER_W), .PASS_W(PASS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic dv_arr [0:DV_N-1];

  function automatic logic [W-1:0] pack(
    input logic [NUM_PE-1:0] wl, il, ps, clr, outv, sel,
    input logic busy, done, cfg,
    input logic [PASS_W-1:0] pc,
    input logic [PH_W-1:0] ph);
    return {wl, il, ps, clr, outv, sel, busy, done, cfg, pc, ph};
  endfunction

  function automatic logic [W-1:0] observe();
    return pack(bus.en_weight_load, bus.en_ifmap_load, bus.en_psum, bus.clear_psum,
                bus.en_output, bus.ifmap_sel_ctrl, bus.busy, bus.done, bus.cfg_err,
                bus.pass_count, bus.phase_count);
  endfunction

  task automatic fill_dv(input int pct_valid);
    for (int c = 0; c < DV_N; c++) dv_arr[c] = ($urandom_range(99) < pct_valid);
  endtask

  // Reference: each pass is one clear cycle then a wavefront of N+NUM_PE phases;
  // PE i works on phases i..i+N-1 and outputs at i+N; invalid cycles do nothing.
  task automatic build_model(input int n, input int p);
    int c;
    int ph;
    logic q;
    logic [NUM_PE-1:0] win, outv;
    exp_q.delete();
    c = 0;
    for (int pi = 0; pi < p; pi++) begin
      exp_q.push_back({1'b1, pack('0, '0, '0, '1, '0, '0, 1'b1, 1'b0, 1'b0,
                                  PASS_W'(pi), '0)});
      c++;
      ph = 0;
      while (ph < n + NUM_PE) begin
        q = STALL_ON ? ((c < DV_N) ? dv_arr[c] : 1'b1) : 1'b1;
        for (int i = 0; i < NUM_PE; i++) begin
          win[i]  = q && (ph >= i) && (ph < i + n);
          outv[i] = q && (ph == i + n);
        end
        exp_q.push_back({1'b1, pack(win, win, win, '0, outv, NUM_PE'(1), 1'b1, 1'b0,
                                    1'b0, PASS_W'(pi), PH_W'(ph))});
        if (q) ph++;
        c++;
      end
    end
    exp_q.push_back({1'b0, pack('0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0,
                                PASS_W'(p - 1), '0)});
  endtask

  // Driver + scoreboard: issue one job, compare every cycle until done, then idle.
  task automatic run_job(input int n, input int p, input int poke, output int lat,
                         output int clr);
    int c;
    logic [EW-1:0] e;
    logic [W-1:0] act, mask;
    build_model(n, p);
    @(negedge clk);
    bus.start          = 1'b1;
    bus.instr_code     = 8'h03;
    bus.num_iterations = ITER_W'(n);
    bus.num_passes     = PASS_W'(p);
    bus.data_valid     = 1'b1;
    @(posedge clk);
    lat = -1;
    clr = 0;
    c = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      bus.start          = (c == poke);
      bus.num_iterations = ITER_W'($urandom);
      bus.num_passes     = PASS_W'($urandom);
      bus.data_valid     = (c < DV_N) ? dv_arr[c] : 1'b1;
      #1;
      e    = exp_q.pop_front();
      act  = observe();
      mask = {{(W - PH_W){1'b1}}, {PH_W{e[W]}}};
      n_checks++;
      if ((act & mask) !== (e[W-1:0] & mask)) begin
        n_fail++;
        $display("FAIL trace n=%0d p=%0d cycle %0d: got %h expected %h", n, p, c, act,
                 e[W-1:0]);
      end
      if (bus.done === 1'b1) lat = c;
      if (bus.clear_psum !== '0) clr++;
      c++;
    end
    @(negedge clk);
    bus.start      = 1'b0;
    bus.data_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_job_idle: busy=%b done=%b cfg_err=%b, required 0 0 0",
               bus.busy, bus.done, bus.cfg_err);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (observe() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", observe());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_pass();
    int lat, clr;
    fill_dv(100);
    run_job(4, 1, -1, lat, clr);
    n_checks++;
    if (lat !== 21 || clr !== 1) begin
      n_fail++;
      $display("FAIL single_pass: done at %0d clears %0d, required 21 and 1", lat, clr);
    end
  endtask

  task automatic test_multi_pass();
    int lat, clr;
    fill_dv(100);
    run_job(4, 3, -1, lat, clr);
    n_checks++;
    if (lat !== 63 || clr !== 3) begin
      n_fail++;
      $display("FAIL multi_pass: done at %0d clears %0d, required 63 and 3", lat, clr);
    end
  endtask

  task automatic test_stall();
    int lat, clr;
    fill_dv(100);
    // cycle 0 is CLEAR, cycle 3 is phase 2
    dv_arr[3] = 1'b0;
    dv_arr[4] = 1'b0;
    dv_arr[5] = 1'b0;
    run_job(4, 1, -1, lat, clr);
    n_checks++;
    if (lat !== (STALL_ON ? 24 : 21)) begin
      n_fail++;
      $display("FAIL stall_latency: done at %0d, required %0d", lat, STALL_ON ? 24 : 21);
    end
  endtask

  task automatic test_cfg_err();
    logic [7:0] ops [0:2];
    int ns [0:2];
    int ps [0:2];
    ops[0] = 8'h03; ns[0] = 0; ps[0] = 2;
    ops[1] = 8'h03; ns[1] = 3; ps[1] = 0;
    ops[2] = 8'h05; ns[2] = 4; ps[2] = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.start          = 1'b1;
      bus.instr_code     = ops[k];
      bus.num_iterations = ITER_W'(ns[k]);
      bus.num_passes     = PASS_W'(ps[k]);
      #1;
      n_checks++;
      if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_pre_%0d: cfg_err=%b busy=%b, required 0 0", k, bus.cfg_err,
                 bus.busy);
      end
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      n_checks++;
      if (bus.cfg_err !== (ops[k] == 8'h03) || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_pulse_%0d: cfg_err=%b busy=%b done=%b, required %b 0 0", k,
                 bus.cfg_err, bus.busy, bus.done, ops[k] == 8'h03);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_after_%0d: cfg_err=%b busy=%b, required 0 0", k, bus.cfg_err,
                 bus.busy);
      end
    end
  endtask

  task automatic test_start_in_run();
    int lat, clr;
    fill_dv(100);
    run_job(5, 2, 10, lat, clr);
    n_checks++;
    if (lat !== 44 || clr !== 2) begin
      n_fail++;
      $display("FAIL start_in_run: done at %0d clears %0d, required 44 and 2", lat, clr);
    end
  endtask

  task automatic test_reset_mid();
    int lat, clr;
    @(negedge clk);
    bus.start          = 1'b1;
    bus.instr_code     = 8'h03;
    bus.num_iterations = ITER_W'(4);
    bus.num_passes     = PASS_W'(3);
    bus.data_valid     = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 29; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1;
    n_checks++;
    if (bus.pass_count !== PASS_W'(1) || bus.phase_count !== PH_W'(7)) begin
      n_fail++;
      $display("FAIL mid_position: pass=%0d phase=%0d, required 1 7", bus.pass_count,
               bus.phase_count);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (observe() !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h required 0", observe());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_idle: busy=%b required 0", bus.busy);
    end
    fill_dv(100);
    run_job(2, 1, -1, lat, clr);
    n_checks++;
    if (lat !== 19) begin
      n_fail++;
      $display("FAIL restart_latency: done at %0d required 19", lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat, clr, n, p;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 20);
      p = $urandom_range(1, 3);
      fill_dv(75);
      run_job(n, p, ($urandom_range(1) == 1) ? $urandom_range(2, 15) : -1, lat, clr);
      n_checks++;
      if (clr !== p) begin
        n_fail++;
        $display("FAIL random_clears job %0d: got %0d required %0d", j, clr, p);
      end
    end
  endtask

  initial begin
    bus.start          = 1'b0;
    bus.instr_code     = 8'h00;
    bus.num_iterations = '0;
    bus.num_passes     = '0;
    bus.data_valid     = 1'b0;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_stall();
    test_cfg_err();
    test_start_in_run();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
